control_demux: RTL and testbench

// - Steering counterpart of the control merge: joins one data channel with one index channel
//   and delivers the data token to output lane outs[index].
// - Used where a merge's index channel later routes a result back to the branch it came from.
// - One-entry registered output slot gives a 1-cycle latency.
// - Full throughput when the selected consumer is ready.

---
 rtl/control_demux.sv | 118 +++++++++++
 tb/tb_control_demux.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_demux.sv
// Joins a data token with a destination index and steers the token to one output lane
// through a single registered slot (1-cycle latency, full throughput when drained).
module control_demux #(
   parameter int unsigned SIZE       = 2,
   parameter int unsigned DATA_TYPE  = 32,
   parameter int unsigned INDEX_TYPE = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_TYPE-1:0]        ins,
   input  logic                        ins_valid,
   output logic                        ins_ready,
   input  logic [INDEX_TYPE-1:0]       index,
   input  logic                        index_valid,
   output logic                        index_ready,
   output logic [SIZE*DATA_TYPE-1:0]   outs,
   output logic [SIZE-1:0]             outs_valid,
   input  logic [SIZE-1:0]             outs_ready,
   output logic                        err
);

   localparam int unsigned IDX_W = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [DATA_TYPE-1:0]   data_q;
   logic [DATA_TYPE-1:0]   data_d;
   logic [SIZE-1:0]        vld_q;
   logic [SIZE-1:0]        vld_d;
   logic                   err_q;
   logic                   err_d;

   logic                   drain_c;
   logic                   free_c;
   logic                   fire_c;
   logic                   idx_ok_c;
   logic [SIZE-1:0]        onehot_c;

   // Lane decode of the incoming index; an out-of-range index decodes to all zeros.
   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         onehot_c[i] = (IDX_W'(index) == IDX_W'(i));
      end
   end

   assign idx_ok_c = (IDX_W'(index) < IDX_W'(SIZE));

   // vld_q is one-hot on the held lane, so masking with outs_ready picks outs_ready[sel].
   assign drain_c = |(vld_q & outs_ready);
   assign free_c  = (state_q == EMPTY) | drain_c;

   // Only combinational path from outs_ready: the readies. Readies drop while in reset.
   assign ins_ready   = rst & index_valid & free_c;
   assign index_ready = rst & ins_valid & free_c;
   assign fire_c      = rst & ins_valid & index_valid & free_c;

   // Slot state register and payload
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         vld_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   // Next-state: load on an in-range fire, drop on an out-of-range fire, else drain or hold.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      vld_d   = vld_q;
      err_d   = err_q;

      case (state_q)
         EMPTY: begin
            if (fire_c && idx_ok_c) begin
               state_d = FULL;
               data_d  = ins;
               vld_d   = onehot_c;
            end
         end
         FULL: begin
            if (fire_c && idx_ok_c) begin
               state_d = FULL;
               data_d  = ins;
               vld_d   = onehot_c;
            end else if (drain_c) begin
               state_d = EMPTY;
               vld_d   = '0;
            end
         end
         default: begin
            state_d = EMPTY;
            vld_d   = '0;
         end
      endcase

      if (fire_c && !idx_ok_c) begin
         err_d = 1'b1;
      end
   end

   assign outs       = {SIZE{data_q}};
   assign outs_valid = vld_q;
   assign err        = err_q;

endmodule

// File: tb/tb_control_demux.sv
// Directed bench for control_demux: a 2-lane instance for the main paths and a 3-lane
// instance with a 2-bit index to exercise out-of-range indices.
module tb_control_demux;

   logic        clk;
   logic        rst;

   logic [31:0] ins_a;
   logic        ins_valid_a;
   logic        ins_ready_a;
   logic [0:0]  index_a;
   logic        index_valid_a;
   logic        index_ready_a;
   logic [63:0] outs_a;
   logic [1:0]  outs_valid_a;
   logic [1:0]  outs_ready_a;
   logic        err_a;

   logic [31:0] ins_b;
   logic        ins_valid_b;
   logic        ins_ready_b;
   logic [1:0]  index_b;
   logic        index_valid_b;
   logic        index_ready_b;
   logic [95:0] outs_b;
   logic [2:0]  outs_valid_b;
   logic [2:0]  outs_ready_b;
   logic        err_b;

   int n_checks;
   int n_fail;

   control_demux #(.SIZE(2), .DATA_TYPE(32), .INDEX_TYPE(1)) dut_a (
      .clk(clk), .rst(rst),
      .ins(ins_a), .ins_valid(ins_valid_a), .ins_ready(ins_ready_a),
      .index(index_a), .index_valid(index_valid_a), .index_ready(index_ready_a),
      .outs(outs_a), .outs_valid(outs_valid_a), .outs_ready(outs_ready_a),
      .err(err_a)
   );

   control_demux #(.SIZE(3), .DATA_TYPE(32), .INDEX_TYPE(2)) dut_b (
      .clk(clk), .rst(rst),
      .ins(ins_b), .ins_valid(ins_valid_b), .ins_ready(ins_ready_b),
      .index(index_b), .index_valid(index_valid_b), .index_ready(index_ready_b),
      .outs(outs_b), .outs_valid(outs_valid_b), .outs_ready(outs_ready_b),
      .err(err_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst           = 1'b0;
      ins_a         = 32'h1111_2222;
      index_a       = 1'b1;
      ins_valid_a   = 1'b1;
      index_valid_a = 1'b1;
      outs_ready_a  = 2'b11;
      ins_b         = 32'h3333_4444;
      index_b       = 2'd3;
      ins_valid_b   = 1'b1;
      index_valid_b = 1'b1;
      outs_ready_b  = 3'b111;
      tick();
      tick();
      n_checks++;
      if (outs_valid_a !== 2'b00) begin
         n_fail++; $display("FAIL reset_outs_valid: got %b expected 00", outs_valid_a);
      end
      n_checks++;
      if (ins_ready_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_ins_ready: got %b expected 0", ins_ready_a);
      end
      n_checks++;
      if (index_ready_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_index_ready: got %b expected 0", index_ready_a);
      end
      n_checks++;
      if (outs_a !== 64'h0) begin
         n_fail++; $display("FAIL reset_outs: got %h expected 0", outs_a);
      end
      n_checks++;
      if (err_a !== 1'b0 || err_b !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got a=%b b=%b expected 0 0", err_a, err_b);
      end
      ins_valid_a   = 1'b0;
      index_valid_a = 1'b0;
      ins_valid_b   = 1'b0;
      index_valid_b = 1'b0;
      rst           = 1'b1;
      tick();
      n_checks++;
      if (outs_valid_a !== 2'b00 || outs_valid_b !== 3'b000) begin
         n_fail++; $display("FAIL post_reset_valid: got a=%b b=%b expected 00 000",
                            outs_valid_a, outs_valid_b);
      end
   endtask

   task automatic test_single();
      ins_a         = 32'hA5A5_0001;
      index_a       = 1'b1;
      ins_valid_a   = 1'b1;
      index_valid_a = 1'b1;
      outs_ready_a  = 2'b11;
      #1;
      n_checks++;
      if (ins_ready_a !== 1'b1 || index_ready_a !== 1'b1) begin
         n_fail++; $display("FAIL single_accept: got ins_ready=%b index_ready=%b expected 1 1",
                            ins_ready_a, index_ready_a);
      end
      tick();
      ins_valid_a   = 1'b0;
      index_valid_a = 1'b0;
      n_checks++;
      if (outs_valid_a !== 2'b10) begin
         n_fail++; $display("FAIL single_valid: got %b expected 10", outs_valid_a);
      end
      n_checks++;
      if (outs_a[63:32] !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL single_data: got %h expected a5a50001", outs_a[63:32]);
      end
      tick();
      n_checks++;
      if (outs_valid_a !== 2'b00) begin
         n_fail++; $display("FAIL single_drain: got %b expected 00", outs_valid_a);
      end
   endtask

   task automatic test_join();
      ins_a         = 32'h0000_0777;
      index_a       = 1'b0;
      ins_valid_a   = 1'b1;
      index_valid_a = 1'b0;
      outs_ready_a  = 2'b11;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (ins_ready_a !== 1'b0 || outs_valid_a !== 2'b00) begin
            n_fail++; $display("FAIL join_wait cycle %0d: got ins_ready=%b outs_valid=%b expected 0 00",
                               c, ins_ready_a, outs_valid_a);
         end
         tick();
      end
      index_valid_a = 1'b1;
      #1;
      n_checks++;
      if (ins_ready_a !== 1'b1) begin
         n_fail++; $display("FAIL join_fire: got %b expected 1", ins_ready_a);
      end
      tick();
      ins_valid_a   = 1'b0;
      index_valid_a = 1'b0;
      n_checks++;
      if (outs_valid_a !== 2'b01 || outs_a[31:0] !== 32'h0000_0777) begin
         n_fail++; $display("FAIL join_out: got valid=%b data=%h expected 01 00000777",
                            outs_valid_a, outs_a[31:0]);
      end
      tick();
   endtask

   task automatic test_backpressure();
      ins_a         = 32'h0000_BEEF;
      index_a       = 1'b0;
      ins_valid_a   = 1'b1;
      index_valid_a = 1'b1;
      outs_ready_a  = 2'b10;
      tick();
      ins_a   = 32'h0000_C0DE;
      index_a = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_checks++;
         if (outs_valid_a !== 2'b01 || outs_a[31:0] !== 32'h0000_BEEF || ins_ready_a !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold cycle %0d: got valid=%b data=%h ins_ready=%b expected 01 0000beef 0",
                               c, outs_valid_a, outs_a[31:0], ins_ready_a);
         end
         tick();
      end
      outs_ready_a = 2'b01;
      #1;
      n_checks++;
      if (ins_ready_a !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_ready: got %b expected 1", ins_ready_a);
      end
      tick();
      ins_valid_a   = 1'b0;
      index_valid_a = 1'b0;
      outs_ready_a  = 2'b11;
      n_checks++;
      if (outs_valid_a !== 2'b10 || outs_a[63:32] !== 32'h0000_C0DE) begin
         n_fail++; $display("FAIL bp_refill: got valid=%b data=%h expected 10 0000c0de",
                            outs_valid_a, outs_a[63:32]);
      end
      tick();
      n_checks++;
      if (outs_valid_a !== 2'b00) begin
         n_fail++; $display("FAIL bp_empty: got %b expected 00", outs_valid_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data;
      logic [1:0]  exp_vld;
      int          lane;
      outs_ready_a = 2'b11;
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin
            lane     = (k - 1) % 2;
            exp_data = 32'h1000_0000 + 32'(k - 1);
            exp_vld  = (lane == 1) ? 2'b10 : 2'b01;
            n_checks++;
            if (outs_valid_a !== exp_vld || outs_a[lane*32 +: 32] !== exp_data) begin
               n_fail++; $display("FAIL stream_out %0d: got valid=%b data=%h expected %b %h",
                                  k - 1, outs_valid_a, outs_a[lane*32 +: 32], exp_vld, exp_data);
            end
         end
         if (k < 8) begin
            ins_a         = 32'h1000_0000 + 32'(k);
            index_a       = 1'(k % 2);
            ins_valid_a   = 1'b1;
            index_valid_a = 1'b1;
            #1;
            n_checks++;
            if (ins_ready_a !== 1'b1) begin
               n_fail++; $display("FAIL stream_ready %0d: got %b expected 1", k, ins_ready_a);
            end
         end else begin
            ins_valid_a   = 1'b0;
            index_valid_a = 1'b0;
         end
         tick();
      end
      n_checks++;
      if (outs_valid_a !== 2'b00) begin
         n_fail++; $display("FAIL stream_empty: got %b expected 00", outs_valid_a);
      end
   endtask

   task automatic test_bad_index();
      ins_b         = 32'h0000_DEAD;
      index_b       = 2'd3;
      ins_valid_b   = 1'b1;
      index_valid_b = 1'b1;
      outs_ready_b  = 3'b111;
      #1;
      n_checks++;
      if (ins_ready_b !== 1'b1 || index_ready_b !== 1'b1) begin
         n_fail++; $display("FAIL bad_consume: got ins_ready=%b index_ready=%b expected 1 1",
                            ins_ready_b, index_ready_b);
      end
      tick();
      ins_b   = 32'h0000_0222;
      index_b = 2'd2;
      n_checks++;
      if (outs_valid_b !== 3'b000 || err_b !== 1'b1) begin
         n_fail++; $display("FAIL bad_drop: got valid=%b err=%b expected 000 1", outs_valid_b, err_b);
      end
      tick();
      ins_valid_b   = 1'b0;
      index_valid_b = 1'b0;
      n_checks++;
      if (outs_valid_b !== 3'b100 || outs_b[95:64] !== 32'h0000_0222) begin
         n_fail++; $display("FAIL bad_next_route: got valid=%b data=%h expected 100 00000222",
                            outs_valid_b, outs_b[95:64]);
      end
      n_checks++;
      if (err_b !== 1'b1) begin
         n_fail++; $display("FAIL bad_sticky: got %b expected 1", err_b);
      end
      tick();
      tick();
      n_checks++;
      if (err_b !== 1'b1 || outs_valid_b !== 3'b000) begin
         n_fail++; $display("FAIL bad_sticky_idle: got err=%b valid=%b expected 1 000", err_b, outs_valid_b);
      end
      n_checks++;
      if (err_a !== 1'b0) begin
         n_fail++; $display("FAIL err_a_clean: got %b expected 0", err_a);
      end
   endtask

   task automatic test_reset_mid();
      ins_a         = 32'h5555_AAAA;
      index_a       = 1'b1;
      ins_valid_a   = 1'b1;
      index_valid_a = 1'b1;
      outs_ready_a  = 2'b00;
      tick();
      ins_valid_a   = 1'b0;
      index_valid_a = 1'b0;
      n_checks++;
      if (outs_valid_a !== 2'b10) begin
         n_fail++; $display("FAIL mid_loaded: got %b expected 10", outs_valid_a);
      end
      #2;
      rst = 1'b0;
      #1;
      n_checks++;
      if (outs_valid_a !== 2'b00 || outs_a !== 64'h0 || err_b !== 1'b0) begin
         n_fail++; $display("FAIL mid_async_clear: got valid=%b outs=%h err_b=%b expected 00 0 0",
                            outs_valid_a, outs_a, err_b);
      end
      tick();
      rst          = 1'b1;
      outs_ready_a = 2'b11;
      tick();
      n_checks++;
      if (outs_valid_a !== 2'b00) begin
         n_fail++; $display("FAIL mid_after_release: got %b expected 00", outs_valid_a);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_join();
      test_backpressure();
      test_back_to_back();
      test_bad_index();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
